// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wide_add_pkg
// Purpose  : Shared constants, operation encoding and helpers for the shared
//            wide adder/subtractor (wide_add_sched) and its sub-modules.
// Contents : DEF_* default widths, op_e encoding, id_bits() width helper.
// Revision : 1.0 - initial release
// ============================================================================
package wide_add_pkg;

  // Default configuration of the shared adder.
  localparam int DEF_N_REQ     = 2;
  localparam int DEF_N_WORDS   = 4;
  localparam int DEF_WORD_BITS = 32;

  // Encoding of the per-requester req_sub bit.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Width of a requester index; never narrower than one bit so that a
  // single-requester build still has a legal (constant zero) id field.
  function automatic int id_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : wide_add_pkg
`default_nettype wire

// File: rtl/wide_add_sched_carry_tree.sv
`default_nettype none
// ============================================================================
// Module   : carry_tree
// Purpose  : Parallel-prefix (Kogge-Stone) carry resolution over per-word
//            generate/propagate bits. c[i] is the carry out of word i given
//            that word 0 has already absorbed its own carry-in.
// Ports    : i_g  [N_WORDS]  word generate (carry out of the raw word sum)
//            i_p  [N_WORDS]  word propagate (raw word sum is all ones)
//            o_c  [N_WORDS]  resolved carry out of each word
// Revision : 1.0 - initial release
// ============================================================================
module carry_tree #(
  parameter int N_WORDS = 4
) (
  input  logic [N_WORDS-1:0] i_g,
  input  logic [N_WORDS-1:0] i_p,
  output logic [N_WORDS-1:0] o_c
);

  // log2(N_WORDS) prefix levels; with N_WORDS == 1 the loop body never runs
  // and the generate bit passes straight through.
  always_comb begin
    logic [N_WORDS-1:0] v_g;
    logic [N_WORDS-1:0] v_p;
    logic [N_WORDS-1:0] v_gn;
    logic [N_WORDS-1:0] v_pn;
    v_g  = i_g;
    v_p  = i_p;
    v_gn = i_g;
    v_pn = i_p;
    for (int d = 1; d < N_WORDS; d = d * 2) begin
      v_gn = v_g;
      v_pn = v_p;
      for (int i = d; i < N_WORDS; i++) begin
        v_gn[i] = v_g[i] | (v_p[i] & v_g[i-d]);
        v_pn[i] = v_p[i] & v_p[i-d];
      end
      v_g = v_gn;
      v_p = v_pn;
    end
    o_c = v_g;
  end

endmodule : carry_tree
`default_nettype wire

// File: rtl/wide_add_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. Combinational one-hot grant searching
//            upward (with wrap) from the requester after the last winner,
//            plus the last-winner pointer register.
// Ports    : clk, rst_n          clock, async active-low reset
//            i_req      [N_REQ]  request vector
//            i_en                grant may be taken this cycle
//            o_grant    [N_REQ]  one-hot (or zero) grant, not gated by i_en
//            o_grant_id [ID_W]   index of the granted requester
//            o_accept            a grant was taken (i_en & any request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import wide_add_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = id_bits(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_accept
);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;

  // Priority starts one past the last winner, so requester r_ptr itself is
  // visited last.
  always_comb begin
    int v_idx;
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    v_idx      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      v_idx = int'(r_ptr) + off;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_found && i_req[v_idx]) begin
        o_grant[v_idx] = 1'b1;
        o_grant_id     = ID_W'(v_idx);
        w_found        = 1'b1;
      end
    end
  end

  assign o_accept = i_en & w_found;

  // Reset to the last requester so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= ID_W'(N_REQ - 1);
    end else if (o_accept) begin
      r_ptr <= o_grant_id;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/wide_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sched
// Purpose  : One pipelined multi-word adder/subtractor shared by N_REQ
//            requesters. Round-robin arbitration, per-word partial sums with
//            generate/propagate (S1), carry resolution by carry_tree (S2),
//            carry injection into the output registers (S3).
// Ports    : clk           clock
//            ctrl_reset_n  async active-low reset
//            req_valid/ready/a/b/sub   per-requester operand ports
//            out_valid/ready           result handshake
//            out_sum, out_cout, out_id result, carry (sub: 1 = no borrow), tag
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_sched
  import wide_add_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int N_WORDS   = DEF_N_WORDS,
  parameter  int WORD_BITS = DEF_WORD_BITS,
  localparam int W         = N_WORDS * WORD_BITS,
  localparam int ID_W      = id_bits(N_REQ)
) (
  input  logic               clk,
  input  logic               ctrl_reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic               out_cout,
  output logic [ID_W-1:0]    out_id
);

  // Stage records depend on the module parameters, so they live here
  // rather than in the package.
  typedef struct packed {
    logic                                valid;
    logic [ID_W-1:0]                     id;
    logic [N_WORDS-1:0][WORD_BITS-1:0]   s;
    logic [N_WORDS-1:0]                  g;
    logic [N_WORDS-1:0]                  p;
  } stage_t;

  typedef struct packed {
    logic                                valid;
    logic [ID_W-1:0]                     id;
    logic [N_WORDS-1:0][WORD_BITS-1:0]   s;
    logic [N_WORDS-1:0]                  c;
  } carry_stage_t;

  // --------------------------------------------------------------------------
  // Pipe enable and arbitration
  // --------------------------------------------------------------------------
  logic               w_adv;
  logic               w_en;
  logic               r_run;
  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_accept;

  // The whole pipe moves as one; a stalled output freezes every stage,
  // bubbles included.
  assign w_adv = ~out_valid | out_ready;

  // r_run keeps req_ready low during reset and for the first edge after
  // release, so no handshake can complete while reset is deasserting.
  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_en = w_adv & r_run;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk        (clk),
    .rst_n      (ctrl_reset_n),
    .i_req      (req_valid),
    .i_en       (w_en),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_accept   (w_accept)
  );

  assign req_ready = w_grant & {N_REQ{w_en}};

  // --------------------------------------------------------------------------
  // Operand selection (grant is one-hot, so an OR-mux is sufficient)
  // --------------------------------------------------------------------------
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_sub;

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sub = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_a   = req_a[k*W +: W];
        w_b   = req_b[k*W +: W];
        w_sub = req_sub[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1: independent word sums. Subtraction folds the +1 of the two's
  // complement into word 0 only; upper words see their carry in S3.
  // --------------------------------------------------------------------------
  logic [N_WORDS-1:0][WORD_BITS-1:0] w_s1_s;
  logic [N_WORDS-1:0]                w_s1_g;
  logic [N_WORDS-1:0]                w_s1_p;

  for (genvar i = 0; i < N_WORDS; i++) begin : g_word
    logic [WORD_BITS-1:0] w_aw;
    logic [WORD_BITS-1:0] w_bw;
    logic                 w_cin;
    logic [WORD_BITS:0]   w_full;

    assign w_aw   = w_a[i*WORD_BITS +: WORD_BITS];
    assign w_bw   = w_sub ? ~w_b[i*WORD_BITS +: WORD_BITS]
                          :  w_b[i*WORD_BITS +: WORD_BITS];
    assign w_cin  = (i == 0) ? w_sub : 1'b0;
    assign w_full = {1'b0, w_aw} + {1'b0, w_bw} + (WORD_BITS+1)'(w_cin);

    assign w_s1_s[i] = w_full[WORD_BITS-1:0];
    assign w_s1_g[i] = w_full[WORD_BITS];
    // An all-ones word turns an incoming carry into an outgoing one.
    assign w_s1_p[i] = &w_full[WORD_BITS-1:0];
  end

  stage_t r_s1;

  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_s1 <= '0;
    end else if (w_adv) begin
      r_s1.valid <= w_accept;
      r_s1.id    <= w_grant_id;
      r_s1.s     <= w_s1_s;
      r_s1.g     <= w_s1_g;
      r_s1.p     <= w_s1_p;
    end
  end

  // --------------------------------------------------------------------------
  // S2: carry resolution across words
  // --------------------------------------------------------------------------
  logic [N_WORDS-1:0] w_c;
  carry_stage_t       r_s2;

  carry_tree #(
    .N_WORDS (N_WORDS)
  ) u_carry (
    .i_g (r_s1.g),
    .i_p (r_s1.p),
    .o_c (w_c)
  );

  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_s2 <= '0;
    end else if (w_adv) begin
      r_s2.valid <= r_s1.valid;
      r_s2.id    <= r_s1.id;
      r_s2.s     <= r_s1.s;
      r_s2.c     <= w_c;
    end
  end

  // --------------------------------------------------------------------------
  // S3: add the resolved carry from the word below. The word carry of this
  // addition is already accounted for in c[], so it is dropped.
  // --------------------------------------------------------------------------
  logic [N_WORDS-1:0][WORD_BITS-1:0] w_out_words;

  for (genvar i = 0; i < N_WORDS; i++) begin : g_out
    if (i == 0) begin : g_lsw
      assign w_out_words[i] = r_s2.s[i];
    end else begin : g_upper
      assign w_out_words[i] = r_s2.s[i] + WORD_BITS'(r_s2.c[i-1]);
    end
  end

  // Data registers only load on a valid result so out_* keep the last
  // result through bubbles as well as through stalls.
  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_id    <= '0;
    end else if (w_adv) begin
      out_valid <= r_s2.valid;
      if (r_s2.valid) begin
        out_sum  <= w_out_words;
        out_cout <= r_s2.c[N_WORDS-1];
        out_id   <= r_s2.id;
      end
    end
  end

endmodule : wide_add_sched
`default_nettype wire
